cmp_sequencer: RTL and testbench
================================

Name: cmp_sequencer

Overview:
- Operand sequencer and result collector wrapped around status_detector.
- Queues (A, B) operand pairs and drives them one at a time onto status_detector in1/in2 from registers.
- Samples the combinational Bout on the following clock and hands each result downstream with valid/ready.
- Keeps a saturating count of borrow results. Bout = 1 iff in1 < in2 (unsigned borrow of in1 - in2).

Parameters:
- WIDTH, 4, operand width; matches status_detector in1/in2.
- DEPTH, 4, operand FIFO entries; power of two, at least 2.
- CNT_W, 8, borrow counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- op_valid  in  1  operand pair offered.
- op_ready  out  1  FIFO can accept; high iff FIFO not full.
- op_a  in  WIDTH  minuend, goes to in1.
- op_b  in  WIDTH  subtrahend, goes to in2.
- in1  out  WIDTH  registered, to status_detector.in1.
- in2  out  WIDTH  registered, to status_detector.in2.
- Bout  in  1  from status_detector.Bout, combinational on in1/in2.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_bout  out  1  captured Bout for the presented pair.
- res_a  out  WIDTH  echo of in1 for the result.
- res_b  out  WIDTH  echo of in2 for the result.
- borrow_count  out  CNT_W  number of accepted results with res_bout=1; saturates.
- clear_count  in  1  synchronous clear of borrow_count.
- fifo_level  out  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: all sequential state is updated only on clk edges where rst_n=0; there are no asynchronous paths. On reset:
  - FIFO emptied; fifo_level=0; op_ready=1.
  - State=IDLE.
  - in1=in2=0; res_valid=0; res_bout=0; res_a=res_b=0; borrow_count=0.
  - Reset mid-operation discards queued pairs and any pending result.
- Push: on an edge with op_valid && op_ready, {op_a, op_b} is written at the tail.
- Pop: the FSM reads the head. A push and a pop on the same edge leave fifo_level unchanged.
- op_ready depends only on fifo_level, so a pop on the same edge does not free a slot early.
- FSM states and transitions:
  - IDLE: if FIFO non-empty, pop head into in1/in2 and go to SAMPLE; otherwise stay.
  - SAMPLE: in1/in2 have been stable for one full cycle. Capture res_bout<=Bout, res_a<=in1, res_b<=in2, res_valid<=1, then go to HOLD.
  - HOLD: hold all res_* and in1/in2 stable while res_valid && !res_ready. On an edge with res_ready=1, clear res_valid and go to IDLE.
- Latency:
  - A push on edge E0 into an empty FIFO in IDLE gives in1/in2 at E1 and res_valid high after E2.
  - Minimum spacing between accepted results is 3 cycles.
- res_ready may be high in advance; the result is still visible for at least one cycle.
- Counter:
  - On an edge where res_valid && res_ready && res_bout, borrow_count increments.
  - Saturates at 2^CNT_W-1 with no wrap.
  - clear_count has priority over an increment on the same edge; the result is 0.
- FIFO pointers wrap modulo DEPTH.
- Full: op_ready=0 and op_valid is ignored. Empty: IDLE waits.
- All widths are unsigned. No arithmetic is done in this block beyond counter and pointer increments.

Decomposition:
- Shared package:
  - State enum {IDLE, SAMPLE, HOLD}.
  - Default WIDTH, DEPTH and CNT_W constants.
  - Saturating-max constant.
- One sub-module: cmp_op_fifo, a synchronous DEPTH x 2*WIDTH FIFO with push, pop, full, empty, level and synchronous active-low reset.
- The FSM, output registers and counter live in cmp_sequencer.
- The bench instantiates status_detector alongside it.

Test Plan:
1. Reset then single pair: push a=0000, b=0001 → in1=0, in2=1 one edge later; res_valid after the next edge with res_bout=1, res_a=0, res_b=1; borrow_count=1 after the handshake.
2. Ordered stream with res_ready tied high: push (1,0), (5,5), (3,9), (15,14) → res_bout sequence 0, 0, 1, 0, with results exactly 3 cycles apart; borrow_count=1.
3. Backpressure/full: res_ready=0 while pushing 6 pairs → op_ready drops after the FIFO is full; results are held stable; releasing res_ready drains all accepted pairs in order with none lost or duplicated.
4. Simultaneous push/pop at level 2: fifo_level stays 2; op_ready stays 1.
5. Counter: force 255 borrow results → count saturates at 255; clear_count asserted on the same edge as an increment → 0.
6. Reset mid-operation: rst_n=0 while in HOLD with 3 pairs queued → next cycle res_valid=0, fifo_level=0, in1=in2=0, borrow_count=0; a new push proceeds normally.

Source files
------------

// File: rtl/cmp_sequencer_pkg.sv
// Shared types and default sizing for the compare sequencer slice.
package cmp_sequencer_pkg;

   localparam int unsigned WIDTH_DEF = 4;
   localparam int unsigned DEPTH_DEF = 4;
   localparam int unsigned CNT_W_DEF = 8;

   // Saturation ceiling of the borrow counter at its default width
   localparam logic [CNT_W_DEF-1:0] CNT_SAT_DEF = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SAMPLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

endpackage

// File: rtl/cmp_op_fifo.sv
// Synchronous operand-pair FIFO; pointers wrap naturally since DEPTH is a power of two.
module cmp_op_fifo #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DW-1:0]            wr_data,
   output logic [DW-1:0]            rd_data_c,
   output logic                     full_c,
   output logic                     empty_c,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic          do_push_c;
   logic          do_pop_c;

   assign full_c    = (level_q == (AW+1)'(DEPTH));
   assign empty_c   = (level_q == '0);
   assign rd_data_c = mem_q[rd_ptr_q];
   assign level     = level_q;
   assign do_push_c = push && !full_c;
   assign do_pop_c  = pop && !empty_c;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (do_push_c) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop_c) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push_c, do_pop_c})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage is left unreset; occupancy alone decides what is valid
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/status_detector.sv
// Unsigned borrow detector: Bout is set when in1 - in2 would underflow.
module status_detector #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             Bout
);

   assign Bout = (in1 < in2);

endmodule

// File: rtl/cmp_sequencer.sv
// Feeds queued operand pairs to an external borrow detector and returns each result with valid/ready.
module cmp_sequencer
   import cmp_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   op_valid,
   output logic                   op_ready,
   input  logic [WIDTH-1:0]       op_a,
   input  logic [WIDTH-1:0]       op_b,
   output logic [WIDTH-1:0]       in1,
   output logic [WIDTH-1:0]       in2,
   input  logic                   Bout,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic                   res_bout,
   output logic [WIDTH-1:0]       res_a,
   output logic [WIDTH-1:0]       res_b,
   output logic [CNT_W-1:0]       borrow_count,
   input  logic                   clear_count,
   output logic [$clog2(DEPTH):0] fifo_level
);

   localparam int unsigned DW = 2 * WIDTH;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [WIDTH-1:0] in1_q, in1_d;
   logic [WIDTH-1:0] in2_q, in2_d;
   logic             res_valid_q, res_valid_d;
   logic             res_bout_q, res_bout_d;
   logic [WIDTH-1:0] res_a_q, res_a_d;
   logic [WIDTH-1:0] res_b_q, res_b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [DW-1:0]    head_c;
   logic             full_c;
   logic             empty_c;
   logic             push_c;
   logic             pop_c;

   // Acceptance depends only on occupancy, so a same-edge pop never frees a slot early
   assign op_ready = !full_c;
   assign push_c   = op_valid && op_ready;

   cmp_op_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_c),
      .pop       (pop_c),
      .wr_data   ({op_a, op_b}),
      .rd_data_c (head_c),
      .full_c    (full_c),
      .empty_c   (empty_c),
      .level     (fifo_level)
   );

   always_comb begin
      state_d     = state_q;
      in1_d       = in1_q;
      in2_d       = in2_q;
      res_valid_d = res_valid_q;
      res_bout_d  = res_bout_q;
      res_a_d     = res_a_q;
      res_b_d     = res_b_q;
      cnt_d       = cnt_q;
      pop_c       = 1'b0;

      case (state_q)
         IDLE: begin
            if (!empty_c) begin
               pop_c   = 1'b1;
               in1_d   = head_c[DW-1:WIDTH];
               in2_d   = head_c[WIDTH-1:0];
               state_d = SAMPLE;
            end
         end
         // Operands have settled for a full cycle; Bout is safe to capture
         SAMPLE: begin
            res_bout_d  = Bout;
            res_a_d     = in1_q;
            res_b_d     = in2_q;
            res_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Clear wins over a coincident increment
      if (clear_count) begin
         cnt_d = '0;
      end else if (res_valid_q && res_ready && res_bout_q && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in1_q       <= '0;
         in2_q       <= '0;
         res_valid_q <= 1'b0;
         res_bout_q  <= 1'b0;
         res_a_q     <= '0;
         res_b_q     <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         in1_q       <= in1_d;
         in2_q       <= in2_d;
         res_valid_q <= res_valid_d;
         res_bout_q  <= res_bout_d;
         res_a_q     <= res_a_d;
         res_b_q     <= res_b_d;
         cnt_q       <= cnt_d;
      end
   end

   assign in1          = in1_q;
   assign in2          = in2_q;
   assign res_valid    = res_valid_q;
   assign res_bout     = res_bout_q;
   assign res_a        = res_a_q;
   assign res_b        = res_b_q;
   assign borrow_count = cnt_q;

endmodule

// File: tb/tb_cmp_sequencer.sv
// Scoreboard bench for cmp_sequencer driving a status_detector alongside it.
module tb_cmp_sequencer;

   localparam int unsigned W  = 4;
   localparam int unsigned D  = 4;
   localparam int unsigned CW = 8;

   typedef logic [2*W:0] exp_t;   // {a, b, bout}

   logic          clk;
   logic          rst_n;
   logic          op_valid;
   logic          op_ready;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic [W-1:0]  in1;
   logic [W-1:0]  in2;
   logic          Bout;
   logic          res_valid;
   logic          res_ready;
   logic          res_bout;
   logic [W-1:0]  res_a;
   logic [W-1:0]  res_b;
   logic [CW-1:0] borrow_count;
   logic          clear_count;
   logic [2:0]    fifo_level;

   int   checks;
   int   failures;
   int   cyc;
   int   exp_cnt;
   exp_t sb[$];
   int   hs_cyc[$];

   cmp_sequencer #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .op_valid     (op_valid),
      .op_ready     (op_ready),
      .op_a         (op_a),
      .op_b         (op_b),
      .in1          (in1),
      .in2          (in2),
      .Bout         (Bout),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_bout     (res_bout),
      .res_a        (res_a),
      .res_b        (res_b),
      .borrow_count (borrow_count),
      .clear_count  (clear_count),
      .fifo_level   (fifo_level)
   );

   status_detector #(.WIDTH(W)) u_sd (
      .in1  (in1),
      .in2  (in2),
      .Bout (Bout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Mid-cycle scoreboard: a result seen with valid&ready here is accepted on the next edge
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         exp_cnt = 0;
      end else begin
         e = '0;
         if (res_valid && res_ready) begin
            hs_cyc.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected: got a=%0d b=%0d bout=%0d, no result expected", res_a, res_b, res_bout);
            end else begin
               e = sb.pop_front();
               if ({res_a, res_b, res_bout} !== e) begin
                  failures++;
                  $display("FAIL sb_result: got a=%0d b=%0d bout=%0d, want a=%0d b=%0d bout=%0d",
                           res_a, res_b, res_bout, e[2*W:W+1], e[W:1], e[0]);
               end
            end
         end
         if (clear_count) exp_cnt = 0;
         else if (res_valid && res_ready && e[0] && exp_cnt < 255) exp_cnt++;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_try(input logic [W-1:0] a, input logic [W-1:0] b, input int max, output bit acc);
      op_valid = 1'b1;
      op_a     = a;
      op_b     = b;
      acc      = 1'b0;
      for (int n = 0; n < max; n++) begin
         if (op_ready) begin
            sb.push_back({a, b, (a < b)});
            step();
            acc = 1'b1;
            break;
         end
         step();
      end
      op_valid = 1'b0;
   endtask

   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
      bit acc;
      push_try(a, b, 50, acc);
      checks++;
      if (!acc) begin
         failures++;
         $display("FAIL push_timeout: op_ready=%0d, want 1 within 50 cycles", op_ready);
      end
   endtask

   task automatic wait_drain(input int max);
      int n;
      n = 0;
      while (sb.size() != 0 && n < max) begin
         step();
         n++;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout: pending=%0d, want 0", sb.size());
      end
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      checks++;
      if ({in1, in2, res_a, res_b} !== '0) begin
         failures++;
         $display("FAIL reset_data: in1=%0d in2=%0d res_a=%0d res_b=%0d, want all 0", in1, in2, res_a, res_b);
      end
      checks++;
      if (res_valid !== 1'b0 || res_bout !== 1'b0) begin
         failures++;
         $display("FAIL reset_res: res_valid=%0d res_bout=%0d, want 0 0", res_valid, res_bout);
      end
      checks++;
      if (borrow_count !== 8'd0 || fifo_level !== 3'd0 || op_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state: count=%0d level=%0d op_ready=%0d, want 0 0 1", borrow_count, fifo_level, op_ready);
      end
   endtask

   task automatic test_single();
      res_ready = 1'b0;
      push(4'd0, 4'd1);
      step();
      checks++;
      if (in1 !== 4'd0 || in2 !== 4'd1 || res_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_in: in1=%0d in2=%0d res_valid=%0d, want 0 1 0", in1, in2, res_valid);
      end
      step();
      checks++;
      if (res_valid !== 1'b1 || res_bout !== 1'b1 || res_a !== 4'd0 || res_b !== 4'd1) begin
         failures++;
         $display("FAIL single_res: valid=%0d bout=%0d a=%0d b=%0d, want 1 1 0 1", res_valid, res_bout, res_a, res_b);
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || borrow_count !== 8'd1) begin
         failures++;
         $display("FAIL single_count: valid=%0d count=%0d, want 0 1", res_valid, borrow_count);
      end
   endtask

   task automatic test_stream();
      clear_count = 1'b1;
      step();
      clear_count = 1'b0;
      hs_cyc.delete();
      res_ready = 1'b1;
      push(4'd1, 4'd0);
      push(4'd5, 4'd5);
      push(4'd3, 4'd9);
      push(4'd15, 4'd14);
      wait_drain(40);
      checks++;
      if (hs_cyc.size() != 4) begin
         failures++;
         $display("FAIL stream_count: results=%0d, want 4", hs_cyc.size());
      end else begin
         for (int i = 1; i < 4; i++) begin
            checks++;
            if (hs_cyc[i] - hs_cyc[i-1] != 3) begin
               failures++;
               $display("FAIL stream_spacing: gap[%0d]=%0d, want 3", i, hs_cyc[i] - hs_cyc[i-1]);
            end
         end
      end
      checks++;
      if (borrow_count !== 8'd1) begin
         failures++;
         $display("FAIL stream_borrow: count=%0d, want 1", borrow_count);
      end
   endtask

   task automatic test_backpressure();
      bit              acc;
      int              nacc;
      logic [W-1:0]    la, lb;
      logic            lbout;
      logic [W-1:0]    pa [6];
      logic [W-1:0]    pb [6];
      res_ready = 1'b0;
      nacc = 0;
      for (int i = 0; i < 6; i++) begin
         pa[i] = W'($urandom_range(0, 15));
         pb[i] = W'($urandom_range(0, 15));
      end
      for (int i = 0; i < 6; i++) begin
         push_try(pa[i], pb[i], 3, acc);
         if (acc) nacc++;
      end
      checks++;
      if (op_ready !== 1'b0 || fifo_level !== 3'd4 || nacc != 5) begin
         failures++;
         $display("FAIL bp_full: op_ready=%0d level=%0d accepted=%0d, want 0 4 5", op_ready, fifo_level, nacc);
      end
      la = res_a;
      lb = res_b;
      lbout = res_bout;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (res_valid !== 1'b1 || res_a !== la || res_b !== lb || res_bout !== lbout) begin
            failures++;
            $display("FAIL bp_hold: valid=%0d a=%0d b=%0d bout=%0d, want 1 %0d %0d %0d",
                     res_valid, res_a, res_b, res_bout, la, lb, lbout);
         end
      end
      res_ready = 1'b1;
      push(pa[5], pb[5]);
      wait_drain(60);
      checks++;
      if (res_valid !== 1'b0 || fifo_level !== 3'd0) begin
         failures++;
         $display("FAIL bp_drain: valid=%0d level=%0d, want 0 0", res_valid, fifo_level);
      end
   endtask

   task automatic test_simul_push_pop();
      res_ready = 1'b0;
      push(4'd2, 4'd3);
      push(4'd7, 4'd1);
      push(4'd8, 4'd8);
      checks++;
      if (fifo_level !== 3'd2 || res_valid !== 1'b1) begin
         failures++;
         $display("FAIL simul_setup: level=%0d valid=%0d, want 2 1", fifo_level, res_valid);
      end
      res_ready = 1'b1;
      step();
      checks++;
      if (fifo_level !== 3'd2 || op_ready !== 1'b1) begin
         failures++;
         $display("FAIL simul_pre: level=%0d op_ready=%0d, want 2 1", fifo_level, op_ready);
      end
      op_valid = 1'b1;
      op_a = 4'd0;
      op_b = 4'd12;
      sb.push_back({4'd0, 4'd12, 1'b1});
      step();
      op_valid = 1'b0;
      checks++;
      if (fifo_level !== 3'd2 || op_ready !== 1'b1) begin
         failures++;
         $display("FAIL simul_level: level=%0d op_ready=%0d, want 2 1", fifo_level, op_ready);
      end
      wait_drain(40);
   endtask

   task automatic test_counter();
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           n;
      clear_count = 1'b1;
      step();
      clear_count = 1'b0;
      res_ready = 1'b1;
      for (int i = 0; i < 258; i++) begin
         a = W'($urandom_range(0, 14));
         b = W'($urandom_range(32'(a) + 1, 15));
         push(a, b);
      end
      wait_drain(100);
      checks++;
      if (borrow_count !== 8'd255 || exp_cnt != 255) begin
         failures++;
         $display("FAIL cnt_sat: count=%0d model=%0d, want 255", borrow_count, exp_cnt);
      end
      res_ready = 1'b0;
      push(4'd2, 4'd9);
      n = 0;
      while (res_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      checks++;
      if (res_valid !== 1'b1 || res_bout !== 1'b1) begin
         failures++;
         $display("FAIL cnt_wait: valid=%0d bout=%0d, want 1 1", res_valid, res_bout);
      end
      res_ready = 1'b1;
      clear_count = 1'b1;
      step();
      clear_count = 1'b0;
      checks++;
      if (borrow_count !== 8'd0 || res_valid !== 1'b0) begin
         failures++;
         $display("FAIL cnt_clear: count=%0d valid=%0d, want 0 0", borrow_count, res_valid);
      end
   endtask

   task automatic test_reset_mid();
      res_ready = 1'b1;
      push(4'd3, 4'd12);
      wait_drain(20);
      checks++;
      if (borrow_count !== 8'd1) begin
         failures++;
         $display("FAIL mid_pre_count: count=%0d, want 1", borrow_count);
      end
      res_ready = 1'b0;
      push(4'd9, 4'd2);
      push(4'd1, 4'd6);
      push(4'd4, 4'd4);
      push(4'd0, 4'd15);
      checks++;
      if (res_valid !== 1'b1 || fifo_level !== 3'd3) begin
         failures++;
         $display("FAIL mid_setup: valid=%0d level=%0d, want 1 3", res_valid, fifo_level);
      end
      rst_n = 1'b0;
      step();
      sb.delete();
      checks++;
      if (res_valid !== 1'b0 || fifo_level !== 3'd0 || in1 !== 4'd0 || in2 !== 4'd0 ||
          borrow_count !== 8'd0 || op_ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset: valid=%0d level=%0d in1=%0d in2=%0d count=%0d op_ready=%0d, want 0 0 0 0 0 1",
                  res_valid, fifo_level, in1, in2, borrow_count, op_ready);
      end
      rst_n = 1'b1;
      res_ready = 1'b1;
      push(4'd4, 4'd7);
      wait_drain(20);
      checks++;
      if (borrow_count !== 8'd1 || fifo_level !== 3'd0) begin
         failures++;
         $display("FAIL mid_after: count=%0d level=%0d, want 1 0", borrow_count, fifo_level);
      end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      cyc         = 0;
      exp_cnt     = 0;
      rst_n       = 1'b0;
      op_valid    = 1'b0;
      op_a        = '0;
      op_b        = '0;
      res_ready   = 1'b0;
      clear_count = 1'b0;
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_simul_push_pop();
      test_counter();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
